frog_controller: RTL and testbench
==================================

FROG_CONTROLLER -- requirements
Module: frog_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of clock cycles a synchronized button must hold stable before it is accepted.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 4, meaning the number of frame_tick pulses ignored after each applied move.
REQ-003 SHALL have parameter WIN_FRAMES, default 60, meaning the number of frame_tick pulses spent in WIN before respawn.
REQ-004 clk  input  1  pixel clock; the single clock for the block.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_up, btn_down, btn_left, btn_right  input  1 each  raw, asynchronous, active-high buttons.
REQ-007 frame_tick  input  1  one-cycle pulse at frame start, synchronous to clk.
REQ-008 frog_x  output  10  top-left x of frog; always a multiple of 32, range 0..608.
REQ-009 frog_y  output  10  top-left y of frog; always a multiple of 32, range 0..448.
REQ-010 win  output  1  high while state is WIN.
REQ-011 score  output  8  completed crossings.

Function
REQ-012 Each button SHALL pass a 2-FF synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-013 A rising edge of any debounced button SHALL be a move request; held buttons SHALL NOT auto-repeat.
REQ-014 Simultaneous requests SHALL resolve with priority up > down > left > right; only one direction is latched.
REQ-015 FSM states SHALL be IDLE, PENDING, COOLDOWN, WIN.
REQ-016 IDLE + request -> PENDING, with the direction latched.
REQ-017 PENDING: requests are ignored; on frame_tick the move is applied at that same edge -> COOLDOWN, or -> WIN if the new frog_y == 0.
REQ-018 Move deltas SHALL be: up y-32, down y+32, left x-32, right x+32; all arithmetic is 10-bit unsigned.
REQ-019 Bounds: a move that would leave x in 0..608 or y in 0..448 SHALL leave position unchanged, but the FSM still enters COOLDOWN.
REQ-020 COOLDOWN SHALL count COOLDOWN_FRAMES frame_ticks, then -> IDLE; requests during COOLDOWN are discarded, not queued.
REQ-021 On WIN entry, score SHALL increment by 1, saturating at 255.
REQ-022 After WIN_FRAMES frame_ticks, frog_x/frog_y SHALL load 288/448 and the FSM -> IDLE; all requests are discarded in WIN.
REQ-023 frog_x/frog_y SHALL change only on a frame_tick edge, so no tear occurs mid-frame.

Reset
REQ-024 While rst_n is low, outputs SHALL be frog_x=288, frog_y=448, win=0, score=0; state IDLE; synchronizers, debouncers and counters cleared, with debounced levels = 0.
REQ-025 Reset asserted mid-PENDING/COOLDOWN/WIN SHALL abort immediately; no partial move and no score change.

Configuration
REQ-026 Macro FROG_WRAP_EN defined: a left move at x=0 SHALL go to 608 and a right move at x=608 SHALL go to 0; vertical bounds still clamp.
REQ-027 FROG_WRAP_EN undefined: horizontal bounds SHALL clamp per REQ-019.

Structure
REQ-028 Shared package frog_pkg SHALL hold GRID_SIZE=32, H_DISPLAY=640, V_DISPLAY=480, START_X=288, START_Y=448, the FSM state enum and the direction encoding.
REQ-029 Sub-module button_debouncer (synchronizer, counter and level output) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=2, WIN_FRAMES=3)
REQ-030 Scenario 1: reset, then btn_up held 10 clk, then frame_tick -> frog_y=416 after that edge, frog_x=288, win=0.
REQ-031 Scenario 2: btn_left glitches 2 clk high -> no request; frog_x stays 288 across 3 frame_ticks.
REQ-032 Scenario 3: at x=608, press right, then frame_tick -> x=608 without the macro, x=0 with FROG_WRAP_EN.
REQ-033 Scenario 4: btn_up and btn_right pressed in the same cycle -> only y-32 is applied; a btn_down press during COOLDOWN is dropped.
REQ-034 Scenario 5: 14 up moves from start -> y=0, win=1, score=1; after 3 frame_ticks x=288, y=448, win=0.
REQ-035 Scenario 6: rst_n pulsed low in PENDING -> outputs at reset values, and no move on the next frame_tick.

Source files
------------

// File: rtl/frog_pkg.sv
// frog_pkg: shared grid geometry, start position, FSM states and move directions
package frog_pkg;
  localparam int GRID_SIZE = 32;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int START_X = 288;
  localparam int START_Y = 448;
  localparam int MAX_X = H_DISPLAY - GRID_SIZE;
  localparam int MAX_Y = V_DISPLAY - GRID_SIZE;
  typedef enum logic [1:0] {IDLE, PENDING, COOLDOWN, WIN} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
endpackage

// File: rtl/frog_controller_debouncer.sv
// button_debouncer: 2-FF synchronizer plus stability counter producing a clean level
// ports: clk, rst_n (async active-low), btn (raw async input), level (debounced output)
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/frog_controller.sv
// frog_controller: debounced grid-step frog movement with cooldown, win/respawn and score
// ports: clk, rst_n (async active-low), btn_up/down/left/right (raw), frame_tick,
//        frog_x/frog_y (grid-aligned position), win, score
// FROG_WRAP_EN: when defined, horizontal moves wrap around the screen edges instead of clamping
module frog_controller
  import frog_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int WIN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       win,
  output logic [7:0] score
);
  localparam int FMAX = COOLDOWN_FRAMES > WIN_FRAMES ? COOLDOWN_FRAMES : WIN_FRAMES;
  localparam int FW = FMAX > 1 ? $clog2(FMAX) : 1;
  localparam logic [9:0] G = 10'(GRID_SIZE);
  logic [3:0] btn, lvl, lvl_q, req;
  state_t state, state_n;
  dir_t dir, dir_n;
  logic [FW-1:0] cnt, cnt_n;
  logic [9:0] x_n, y_n, mx, my, edge_l, edge_r;
  logic [7:0] score_n;
  assign btn = {btn_right, btn_left, btn_down, btn_up};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .btn(btn[i]), .level(lvl[i])
    );
  end
  // only the cycle a debounced level rises counts, so held buttons never repeat
  assign req = lvl & ~lvl_q;
  assign win = state == WIN;
`ifdef FROG_WRAP_EN
  assign edge_l = 10'(MAX_X);
  assign edge_r = '0;
`else
  assign edge_l = frog_x;
  assign edge_r = frog_x;
`endif
  always_comb begin
    mx = frog_x;
    my = frog_y;
    case (dir)
      DIR_UP:   my = frog_y == '0 ? frog_y : frog_y - G;
      DIR_DOWN: my = frog_y >= 10'(MAX_Y) ? frog_y : frog_y + G;
      DIR_LEFT: mx = frog_x == '0 ? edge_l : frog_x - G;
      default:  mx = frog_x >= 10'(MAX_X) ? edge_r : frog_x + G;
    endcase
  end
  always_comb begin
    state_n = state;
    dir_n = dir;
    cnt_n = cnt;
    x_n = frog_x;
    y_n = frog_y;
    score_n = score;
    case (state)
      IDLE: if (|req) begin
        state_n = PENDING;
        dir_n = req[0] ? DIR_UP : req[1] ? DIR_DOWN : req[2] ? DIR_LEFT : DIR_RIGHT;
      end
      PENDING: if (frame_tick) begin
        x_n = mx;
        y_n = my;
        cnt_n = '0;
        state_n = my == '0 ? WIN : COOLDOWN;
        score_n = my == '0 && score != 8'hFF ? score + 8'd1 : score;
      end
      COOLDOWN: if (frame_tick) begin
        cnt_n = cnt == FW'(COOLDOWN_FRAMES - 1) ? '0 : cnt + 1'b1;
        state_n = cnt == FW'(COOLDOWN_FRAMES - 1) ? IDLE : COOLDOWN;
      end
      default: if (frame_tick) begin
        cnt_n = cnt + 1'b1;
        if (cnt == FW'(WIN_FRAMES - 1)) begin
          cnt_n = '0;
          state_n = IDLE;
          x_n = 10'(START_X);
          y_n = 10'(START_Y);
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= DIR_UP;
      cnt <= '0;
      frog_x <= 10'(START_X);
      frog_y <= 10'(START_Y);
      score <= '0;
      lvl_q <= '0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      cnt <= cnt_n;
      frog_x <= x_n;
      frog_y <= y_n;
      score <= score_n;
      lvl_q <= lvl;
    end
endmodule

// File: tb/tb_frog_controller.sv
// tb_frog_controller: randomized check of frog_controller against a transaction-level model
module tb_frog_controller;
  logic clk = 0, rst_n = 0, frame_tick = 0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic [9:0] frog_x, frog_y;
  logic win;
  logic [7:0] score;
  int n_cmp = 0, n_err = 0;
  int m_x = 288, m_y = 448, m_score = 0, m_cd = 0, m_wr = 0, m_pend = -1;

  always #5 clk = ~clk;

  frog_controller #(.DEBOUNCE_CYCLES(4), .COOLDOWN_FRAMES(2), .WIN_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .frame_tick(frame_tick), .frog_x(frog_x), .frog_y(frog_y),
    .win(win), .score(score)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"}, 32'(frog_x), m_x);
    check({tag, ".y"}, 32'(frog_y), m_y);
    check({tag, ".win"}, 32'(win), m_wr > 0);
    check({tag, ".score"}, 32'(score), m_score);
  endtask

  task automatic set_btn(input logic [3:0] m);
    {btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  // a press is held long enough to debounce, then released and allowed to settle
  task automatic press(input logic [3:0] m);
    @(negedge clk) set_btn(m);
    repeat (10) @(negedge clk);
    set_btn(4'b0);
    repeat (10) @(negedge clk);
    if (m != 0 && m_pend < 0 && m_cd == 0 && m_wr == 0)
      m_pend = m[0] ? 0 : m[1] ? 1 : m[2] ? 2 : 3;
  endtask

  task automatic glitch(input logic [3:0] m);
    @(negedge clk) set_btn(m);
    repeat (2) @(negedge clk);
    set_btn(4'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1;
    @(negedge clk) frame_tick = 0;
    if (m_pend >= 0) begin
      case (m_pend)
        0: if (m_y >= 32) m_y -= 32;
        1: if (m_y + 32 <= 448) m_y += 32;
        2: if (m_x >= 32) m_x -= 32;
`ifdef FROG_WRAP_EN
           else m_x = 608;
`endif
        default: if (m_x + 32 <= 608) m_x += 32;
`ifdef FROG_WRAP_EN
           else m_x = 0;
`endif
      endcase
      m_pend = -1;
      if (m_y == 0) begin
        m_wr = 3;
        m_score = m_score < 255 ? m_score + 1 : 255;
      end else m_cd = 2;
    end else if (m_cd > 0) m_cd--;
    else if (m_wr > 0) begin
      m_wr--;
      if (m_wr == 0) begin
        m_x = 288;
        m_y = 448;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 0;
    repeat (2) @(negedge clk);
    m_x = 288; m_y = 448; m_score = 0; m_cd = 0; m_wr = 0; m_pend = -1;
    check_all("rst_low");
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
    press(4'b0001); tick();
    check_all("s1_up");
    check("s1_y_const", 32'(frog_y), 416);
    tick(); tick();
    glitch(4'b0100);
    repeat (3) tick();
    check_all("s2_glitch");
    for (int k = 0; k < 10; k++) begin
      press(4'b1000); tick(); tick(); tick();
    end
    check_all("s3_at_edge");
    press(4'b1000); tick();
    check_all("s3_edge_right");
    tick(); tick();
    press(4'b1001); tick();
    check_all("s4_priority");
    press(4'b0010); tick(); tick();
    check_all("s4_cooldown_drop");
    do_reset();
    for (int k = 0; k < 14; k++) begin
      press(4'b0001); tick();
      if (k < 13) begin tick(); tick(); end
    end
    check_all("s5_win");
    check("s5_score_const", 32'(score), 1);
    repeat (3) tick();
    check_all("s5_respawn");
    press(4'b0001);
    do_reset();
    tick();
    check_all("s6_abort");
    for (int k = 0; k < 350; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) press(4'($urandom_range(1, 15)));
      else if (r < 88) tick();
      else if (r < 95) glitch(4'($urandom_range(1, 15)));
      else do_reset();
      check_all($sformatf("rnd%0d", k));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
